// File: rtl/serial_subtractor_pkg.sv
// Shared encodings for the bit-serial subtractor.
// FSM states, borrow states and default operand width.
package serial_subtractor_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    NB = 1'b0,
    BR = 1'b1
  } brw_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Busy/Done handshake and data bus of the serial subtractor.
// master: controller side; slave: subtractor side.
interface serial_subtractor_if #(
  parameter int N = serial_subtractor_pkg::DEF_N
);
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Diff;
  logic         BorrowOut;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, A, B,
    input  Diff, BorrowOut, Busy, Done
  );

  modport slave (
    input  Start, A, B,
    output Diff, BorrowOut, Busy, Done
  );
endinterface

// File: rtl/serial_subtractor_shift_reg.sv
// W-bit register: parallel load, right shift, serial-in at MSB.
// Ports: clk, rst_n, load/load_val, shift/sin, q.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = load_val;
    else if (shift)
      q_d = {sin, q_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B (mod 2^N), LSB first, with final borrow.
// Ports: Clock, Reset (async, active-low), bus (slave modport).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic Clock,
  input logic Reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  brw_e          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bout_q, bout_d;

  logic [N-1:0] a_w, b_w, diff_w;
  logic         accept, run;
  logic         a0, b0, br;
  logic         d_bit, br_nxt;

  assign run    = (state_q == RUN);
  assign accept = bus.Start & ~run;

  assign a0     = a_w[0];
  assign b0     = b_w[0];
  assign br     = (br_q == BR);
  assign d_bit  = a0 ^ b0 ^ br;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);

  serial_shift_reg #(.W(N)) u_a (
    .clk(Clock), .rst_n(Reset),
    .load(accept), .load_val(bus.A),
    .shift(run), .sin(1'b0), .q(a_w)
  );

  serial_shift_reg #(.W(N)) u_b (
    .clk(Clock), .rst_n(Reset),
    .load(accept), .load_val(bus.B),
    .shift(run), .sin(1'b0), .q(b_w)
  );

  // Result enters at the MSB so bit 0 ends up as the first bit computed.
  serial_shift_reg #(.W(N)) u_diff (
    .clk(Clock), .rst_n(Reset),
    .load(accept), .load_val('0),
    .shift(run), .sin(d_bit), .q(diff_w)
  );

  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          br_d    = NB;
          cnt_d   = CNT_N;
          busy_d  = 1'b1;
          bout_d  = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        br_d  = br_nxt ? BR : NB;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = br_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      br_q    <= NB;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.Diff      = diff_w;
  assign bus.BorrowOut = bout_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor, the inverse operation of the team's serial adder datapath. It computes Diff = A - B (mod 2^N) one bit per clock, LSB first, and also reports the final borrow. It loads both operands in parallel, shifts them out internally through a borrow-tracking FSM, and shifts the difference bits back into a parallel result register. A Start/Busy/Done handshake lets a controller sequence back-to-back operations.

Parameters:
N, 8, operand and result width in bits (N >= 2)

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only in IDLE or DONE
A  input  N  minuend, captured on an accepted Start
B  input  N  subtrahend, captured on an accepted Start
Diff  output  N  result register; valid while Done=1, held until the next accepted Start
BorrowOut  output  1  final borrow (1 means A < B unsigned); valid and held like Diff
Busy  output  1  high while bits are being processed
Done  output  1  one-cycle pulse when Diff and BorrowOut become valid

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, operand registers=0, Diff=0, BorrowOut=0, Busy=0, Done=0, bit counter=0, borrow flop=0. Reset asserted mid-RUN aborts the operation immediately; no Done is produced.
- Control FSM has three states: IDLE, RUN, DONE.
  - IDLE -> RUN on Start=1.
  - RUN -> DONE when the bit counter reaches 0.
  - DONE -> RUN on Start=1; otherwise DONE -> IDLE. DONE lasts exactly one cycle.
- Accepted Start, at clock edge 0:
  - Load A and B into the operand shift registers.
  - Clear the borrow flop, set the counter to N, clear Diff.
- Start while in RUN is ignored and has no effect on the operation in flight.
- RUN, at each clock edge k = 1..N, with a0/b0 the current LSBs and br the borrow flop:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the Diff MSB; Diff shifts right. After N shifts, bit 0 of Diff is the first computed bit.
  - Shift A and B right, filling with 0.
  - Decrement the counter.
- The borrow flop is the two-state serial machine: state NB (no borrow) and state BR (borrow).
- At edge N, BorrowOut is written with br_next.
- Latency: Start at edge 0 gives Done=1 in the cycle after edge N, i.e. N+1 edges after Start. Busy=1 from edge 0 up to edge N. Busy and Done are never high together.
- Throughput: with Start held or re-asserted during the DONE cycle, a new operation begins with no idle cycle, so one result is produced every N+1 cycles.
- Counter width is clog2(N+1) bits. No arithmetic overflow flag is required; the result wraps mod 2^N.
- A and B may change freely when they are not being sampled.

Decomposition:
- Shared include or package holds:
  - the FSM state encodings (IDLE, RUN, DONE)
  - the borrow-state encodings (NB, BR)
  - the default width constant
- One natural sub-module: serial_shift_reg, a parameterised N-bit register with parallel load, shift enable and a serial-in bit.
  - Instantiate it three times: minuend, subtrahend and Diff.
  - The FSM, counter and borrow logic stay in the top module.

Test Plan:
- A=100, B=37, Start pulse -> Done after 9 edges, Diff=63, BorrowOut=0; Busy high for exactly 8 cycles.
- A=37, B=100 -> Diff=193 (8'hC1), BorrowOut=1.
- Corner cases:
  - A=0, B=1 -> Diff=255, BorrowOut=1
  - A=255, B=1 -> Diff=254, BorrowOut=0
  - A=0, B=0 -> Diff=0, BorrowOut=0
- Start pulsed again mid-RUN with different operands -> ignored; the original result is delivered on schedule.
- Start held high continuously with A=200, B=55 -> Done pulses every 9 cycles, Diff=145 each time, no IDLE cycle between operations.
- Reset driven low at edge 4 of RUN -> all outputs 0 immediately (asynchronous); no Done. A fresh Start after reset release gives the correct result.
